// File: rtl/fpmul_shiftadd_core_if.sv
// rtl/fpmul_shiftadd_core_if.sv - start/done handshake and operand/result bundle for the multiplier core
interface fpmul_shiftadd_core_if #(
  parameter int W = 32
);
  logic         start;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         busy;
  logic         done;
  logic [W-1:0] tmp_result;

  modport master (
    output start, in1, in2,
    input  busy, done, tmp_result
  );

  modport slave (
    input  start, in1, in2,
    output busy, done, tmp_result
  );
endinterface

// File: rtl/fpmul_shiftadd_core.sv
// rtl/fpmul_shiftadd_core.sv - sequential single-precision multiplier using a radix-2 shift-add loop
module fpmul_shiftadd_core #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 127
) (
  input  logic                  clk,
  input  logic                  rst,
  fpmul_shiftadd_core_if.slave  bus
);
  localparam int DW    = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 1;
  localparam int ACC_W = 2 * SIG_W;
  localparam int EW    = EXP_W + 2;
  localparam int CNT_W = $clog2(SIG_W);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SIG_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_t;

  state_t                 r_state;
  logic                   r_sign;
  logic [SIG_W-1:0]       r_ma;
  logic [SIG_W-1:0]       r_mb;
  logic signed [EW-1:0]   r_exp;
  logic [ACC_W-1:0]       r_acc;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_busy;
  logic                   r_done;
  logic [DW-1:0]          r_result;
  logic [DW-1:0]          r_pend;

  logic [EXP_W-1:0]       w_ea;
  logic [EXP_W-1:0]       w_eb;
  logic [EW-1:0]          w_exp_in;
  logic                   w_top;
  logic [MAN_W-1:0]       w_man;
  logic signed [EW-1:0]   w_exp_n;
  logic [DW-1:0]          w_norm_res;

  assign w_ea     = bus.in1[DW-2 -: EXP_W];
  assign w_eb     = bus.in2[DW-2 -: EXP_W];
  // Biased sum minus one bias; two guard bits keep over/underflow visible as a signed value
  assign w_exp_in = {2'b00, w_ea} + {2'b00, w_eb} - EW'(BIAS);

  // Normalize the finished product and select the special-range encodings
  always_comb begin
    w_top      = r_acc[ACC_W-1];
    w_man      = w_top ? r_acc[ACC_W-2 -: MAN_W] : r_acc[ACC_W-3 -: MAN_W];
    w_exp_n    = w_top ? (r_exp + EW'(1)) : r_exp;
    w_norm_res = {r_sign, {(DW-1){1'b0}}};
    if (r_acc == '0) begin
      w_norm_res = {r_sign, {(DW-1){1'b0}}};
    end else if (w_exp_n >= EXP_MAX) begin
      w_norm_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_exp_n <= $signed(EW'(0))) begin
      w_norm_res = {r_sign, {(DW-1){1'b0}}};
    end else begin
      w_norm_res = {r_sign, w_exp_n[EXP_W-1:0], w_man};
    end
  end

  // Control FSM with registered busy/done/result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sign   <= 1'b0;
      r_ma     <= '0;
      r_mb     <= '0;
      r_exp    <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_pend   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_sign  <= bus.in1[DW-1] ^ bus.in2[DW-1];
            r_ma    <= {|w_ea, bus.in1[MAN_W-1:0]};
            r_mb    <= {|w_eb, bus.in2[MAN_W-1:0]};
            r_exp   <= w_exp_in;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          if (r_mb[0]) begin
            r_acc <= r_acc + ({{SIG_W{1'b0}}, r_ma} << r_cnt);
          end
          r_mb  <= r_mb >> 1;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          r_pend  <= w_norm_res;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_result <= r_pend;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.tmp_result = r_result;
endmodule

// File: tb/tb_fpmul_shiftadd_core.sv
// tb/tb_fpmul_shiftadd_core.sv - self-checking bench for the shift-add float multiplier core
module tb_fpmul_shiftadd_core;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fpmul_shiftadd_core_if bus ();

  fpmul_shiftadd_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference product straight from the arithmetic rules: full integer multiply, then normalize
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    int                ea, eb, e;
    longint unsigned   ma, mb, p;
    logic [22:0]       m;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = (ea != 0 ? 64'h80_0000 : 64'h0) + longint'(a[22:0]);
    mb = (eb != 0 ? 64'h80_0000 : 64'h0) + longint'(b[22:0]);
    p  = ma * mb;
    e  = ea + eb - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    if (p == 0)    return {s, 31'h0};
    if (e >= 255)  return {s, 8'hFF, 23'h0};
    if (e <= 0)    return {s, 31'h0};
    return {s, e[7:0], m};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.in1   = a;
    bus.in2   = b;
    step();
    bus.start = 1'b0;
    bus.in1   = $urandom;
    bus.in2   = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.done && n < 40);
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (bus.done) cnt++;
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp;
    int          n;
    exp = model(a, b);
    launch(a, b);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_done(n);
    check({tag, "_lat"}, 32'(n), 32'd26);
    check({tag, "_res"}, bus.tmp_result, exp);
    step();
    check({tag, "_pulse"}, 32'({bus.done, bus.busy}), 32'd0);
    check({tag, "_hold"}, bus.tmp_result, exp);
  endtask

  initial begin
    int          n;
    int          cnt;
    logic [31:0] a, b, r1;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;
    repeat (3) step();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_res", bus.tmp_result, 32'h0);
    rst = 1'b0;
    step();

    // Directed cases
    run(32'h4000_0000, 32'h4040_0000, "two_x_three");
    check("two_x_three_const", bus.tmp_result, 32'h40C0_0000);
    run(32'h3FC0_0000, 32'h3FC0_0000, "norm_top");
    check("norm_top_const", bus.tmp_result, 32'h4010_0000);
    run(32'hBF80_0000, 32'h4000_0000, "neg_pos");
    check("neg_pos_const", bus.tmp_result, 32'hC000_0000);
    run(32'hBF80_0000, 32'hBF80_0000, "neg_neg");
    check("neg_neg_const", bus.tmp_result, 32'h3F80_0000);
    run(32'h7F00_0000, 32'h7F00_0000, "overflow");
    check("overflow_const", bus.tmp_result, 32'h7F80_0000);
    run(32'h0080_0000, 32'h0080_0000, "underflow");
    check("underflow_const", bus.tmp_result, 32'h0000_0000);
    run(32'h8000_0000, 32'h3F80_0000, "neg_zero");
    check("neg_zero_const", bus.tmp_result, 32'h8000_0000);
    run(32'hFF80_0000, 32'h3F80_0000, "inf_sign");

    // Start re-pulsed mid-multiply must not disturb the running operation
    launch(32'h4000_0000, 32'h4040_0000);
    repeat (5) step();
    bus.start = 1'b1;
    bus.in1   = 32'h3FC0_0000;
    bus.in2   = 32'h3FC0_0000;
    step();
    bus.start = 1'b0;
    wait_done(n);
    check("ignore_lat", 32'(n), 32'd20);
    check("ignore_res", bus.tmp_result, 32'h40C0_0000);
    count_dones(30, cnt);
    check("ignore_single_done", 32'(cnt), 32'd0);
    check("ignore_idle", 32'(bus.busy), 32'd0);

    // Start held high: second operation launches in the IDLE cycle right after done
    a = 32'h3FC0_0000;
    b = 32'hC040_0000;
    bus.start = 1'b1;
    bus.in1   = 32'h4000_0000;
    bus.in2   = 32'h4040_0000;
    step();
    bus.in1 = a;
    bus.in2 = b;
    wait_done(n);
    check("held_lat1", 32'(n), 32'd26);
    check("held_res1", bus.tmp_result, 32'h40C0_0000);
    step();
    bus.start = 1'b0;
    check("held_busy2", 32'(bus.busy), 32'd1);
    wait_done(n);
    check("held_lat2", 32'(n), 32'd26);
    check("held_res2", bus.tmp_result, model(a, b));
    step();

    // Reset in the middle of the multiply discards the operation
    launch(32'h4000_0000, 32'h4040_0000);
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_res", bus.tmp_result, 32'h0);
    count_dones(30, cnt);
    check("midrst_no_done", 32'(cnt), 32'd0);
    run(32'h4000_0000, 32'h4040_0000, "after_rst");
    check("after_rst_const", bus.tmp_result, 32'h40C0_0000);

    // Randomized operands against the reference model
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 4 != 0) begin
        a[30:23] = 8'($urandom_range(60, 195));
        b[30:23] = 8'($urandom_range(60, 195));
      end
      r1 = model(a, b);
      launch(a, b);
      wait_done(n);
      check($sformatf("rand%0d_lat", i), 32'(n), 32'd26);
      check($sformatf("rand%0d_res", i), bus.tmp_result, r1);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
